if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/if_stage_if.sv | 39 +++
 rtl/if_next_pc.sv | 27 ++
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch/decode definitions: next-PC select encodings, instruction field layout, fetch FSM states.
// IF_MISALIGN_TRAP_EN adds the TRAP state for misaligned ALU jump targets.
package cpu_pkg;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_IMM  = 2'b01;
  localparam logic [1:0] PC_ALU  = 2'b10;

  localparam int OPCODE_LSB = 28;
  localparam int FUNC_LSB   = 24;
  localparam int RD_LSB     = 20;
  localparam int RS1_LSB    = 16;
  localparam int RS2_LSB    = 12;
  localparam int IMM_LSB    = 0;
  localparam int REG_W      = 4;
  localparam int IMM_W      = 16;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_HOLD,
    ST_WAIT
`ifdef IF_MISALIGN_TRAP_EN
    , ST_TRAP
`endif
  } if_state_e;

  typedef struct packed {
    logic [REG_W-1:0] opcode;
    logic [REG_W-1:0] func;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } fields_t;

  // rs2 and imm overlap in [15:12]; both views are always produced.
  function automatic fields_t decode_instr(input logic [31:0] instr);
    fields_t f;
    f.opcode = instr[OPCODE_LSB +: REG_W];
    f.func   = instr[FUNC_LSB   +: REG_W];
    f.rd     = instr[RD_LSB     +: REG_W];
    f.rs1    = instr[RS1_LSB    +: REG_W];
    f.rs2    = instr[RS2_LSB    +: REG_W];
    f.imm    = instr[IMM_LSB    +: IMM_W];
    return f;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bus bundle of the fetch stage: instruction memory side, decoder handshake, held fields and next-PC controls.
// IF_MISALIGN_TRAP_EN adds the misalign status signal.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  opcode;
  logic [3:0]  func;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [15:0] imm;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_sel;
  logic [31:0] alu_target;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  modport master (
`ifdef IF_MISALIGN_TRAP_EN
    output misalign,
`endif
    output imem_req, imem_addr, out_valid, opcode, func, rd, rs1, rs2, imm, pc, pc_plus4,
    input  imem_ack, imem_rdata, out_ready, pc_sel, alu_target
  );

  modport slave (
`ifdef IF_MISALIGN_TRAP_EN
    input  misalign,
`endif
    input  imem_req, imem_addr, out_valid, opcode, func, rd, rs1, rs2, imm, pc, pc_plus4,
    output imem_ack, imem_rdata, out_ready, pc_sel, alu_target
  );
endinterface

// File: rtl/if_next_pc.sv
// Combinational next-PC selection: sequential, PC-relative branch or word-aligned ALU target.
module if_next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_target,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;

  assign seq_pc = pc + 32'd4;
  assign br_off = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    next_pc = seq_pc;
    case (pc_sel)
      PC_IMM:  next_pc = seq_pc + br_off;
      PC_ALU:  next_pc = alu_target & ~32'h3;
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: FETCH/HOLD/WAIT sequencer with request timeout and re-issue.
// IF_MISALIGN_TRAP_EN traps misaligned ALU jump targets in a sticky TRAP state.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0040,
  parameter int          IMEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  if_stage_if.master bus
);

  localparam int CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;

  if_state_e          state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [3:0]         to_cnt_q, to_cnt_d;
  logic [31:0]        next_pc;
  logic               misalign_hit;
  fields_t            fields;

  assign fields = decode_instr(instr_q);

  if_next_pc u_next_pc (
    .pc         (pc_q),
    .imm        (fields.imm),
    .pc_sel     (bus.pc_sel),
    .alu_target (bus.alu_target),
    .next_pc    (next_pc)
  );

`ifdef IF_MISALIGN_TRAP_EN
  assign misalign_hit = (bus.pc_sel == PC_ALU) && (bus.alu_target[1:0] != 2'b00);
`else
  assign misalign_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every _d takes its held value first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    wait_cnt_d = wait_cnt_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      ST_WAIT: begin
        state_d    = ST_FETCH;
        wait_cnt_d = '0;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          state_d    = ST_HOLD;
          wait_cnt_d = '0;
          to_cnt_d   = '0;
        end else if (wait_cnt_q == CNT_W'(IMEM_TIMEOUT - 1)) begin
          // Drop the request for the single WAIT cycle, then retry the same address.
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
          to_cnt_d   = (to_cnt_q == 4'hF) ? to_cnt_q : to_cnt_q + 4'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
`ifdef IF_MISALIGN_TRAP_EN
          if (misalign_hit) begin
            state_d = ST_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = ST_WAIT;
          end
`else
          pc_d    = next_pc;
          state_d = misalign_hit ? ST_WAIT : ST_WAIT;
`endif
        end
      end
`ifdef IF_MISALIGN_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_WAIT;
    endcase
  end

  // Reset parks in WAIT so the request rises on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= ST_WAIT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      wait_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      wait_cnt_q <= wait_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign bus.imem_req  = (state_q == ST_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.opcode    = fields.opcode;
  assign bus.func      = fields.func;
  assign bus.rd        = fields.rd;
  assign bus.rs1       = fields.rs1;
  assign bus.rs2       = fields.rs2;
  assign bus.imm       = fields.imm;
  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_q + 32'd4;
`ifdef IF_MISALIGN_TRAP_EN
  assign bus.misalign  = (state_q == ST_TRAP);
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, fetch/hold handshake, next-PC modes, wrap, timeout, mid-fetch reset, misaligned target.
module tb_if_stage;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] word);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    step();
    bus.imem_ack   = 1'b0;
  endtask

  task automatic accept(input logic [1:0] sel, input logic [31:0] tgt);
    bus.out_ready  = 1'b1;
    bus.pc_sel     = sel;
    bus.alu_target = tgt;
    step();
    bus.out_ready  = 1'b0;
    bus.pc_sel     = PC_NEXT;
    bus.alu_target = 32'h0;
  endtask

  task automatic jump_to(input logic [31:0] addr);
    do_fetch(32'h0);
    accept(PC_ALU, addr);
    step();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req got %0b exp 0", bus.imem_req);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b exp 0", bus.out_valid);
    end
    checks++;
    if (bus.pc !== 32'h40) begin
      errors++; $display("FAIL reset_pc got %08h exp 00000040", bus.pc);
    end
    checks++;
    if ({bus.opcode, bus.func, bus.rd, bus.rs1, bus.rs2, bus.imm} !== 36'h0) begin
      errors++; $display("FAIL reset_fields got %09h exp 0",
                         {bus.opcode, bus.func, bus.rd, bus.rs1, bus.rs2, bus.imm});
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
      errors++; $display("FAIL first_req got req=%0b addr=%08h exp req=1 addr=00000040",
                         bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_fetch();
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_wait got req=%0b addr=%08h valid=%0b exp 1/00000040/0",
                         bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    do_fetch(32'h8123_ABCD);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL fetch_valid got valid=%0b req=%0b exp 1/0", bus.out_valid, bus.imem_req);
    end
    checks++;
    if ({bus.opcode, bus.func, bus.rd, bus.rs1, bus.rs2, bus.imm} !== 36'h8123AABCD) begin
      errors++; $display("FAIL fetch_fields got %09h exp 8123aabcd",
                         {bus.opcode, bus.func, bus.rd, bus.rs1, bus.rs2, bus.imm});
    end
    checks++;
    if (bus.pc !== 32'h40 || bus.pc_plus4 !== 32'h44) begin
      errors++; $display("FAIL fetch_pc got pc=%08h pc4=%08h exp 00000040/00000044", bus.pc, bus.pc_plus4);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      bus.imem_ack   = (i == 2);
      bus.imem_rdata = 32'h5555_0000;
      step();
      checks++;
      if ({bus.out_valid, bus.opcode, bus.func, bus.rd, bus.rs1, bus.rs2, bus.imm, bus.pc}
          !== {1'b1, 36'h8123AABCD, 32'h40}) begin
        errors++; $display("FAIL hold_%0d got valid=%0b fields=%09h pc=%08h exp 1/8123aabcd/00000040",
                           i, bus.out_valid, {bus.opcode, bus.func, bus.rd, bus.rs1, bus.rs2, bus.imm}, bus.pc);
      end
    end
    bus.imem_ack = 1'b0;
    accept(PC_NEXT, 32'h0);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL wait_cycle got req=%0b valid=%0b exp 0/0", bus.imem_req, bus.out_valid);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h44) begin
      errors++; $display("FAIL seq_next got req=%0b addr=%08h exp 1/00000044", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    jump_to(32'h100);
    checks++;
    if (bus.imem_addr !== 32'h100) begin
      errors++; $display("FAIL alu_jump got %08h exp 00000100", bus.imem_addr);
    end
    do_fetch(32'h1000_FFFF);
    accept(PC_IMM, 32'h0);
    step();
    checks++;
    if (bus.imem_addr !== 32'h100) begin
      errors++; $display("FAIL imm_neg got %08h exp 00000100", bus.imem_addr);
    end
    do_fetch(32'h1000_0003);
    accept(2'b11, 32'h0);
    step();
    checks++;
    if (bus.imem_addr !== 32'h104) begin
      errors++; $display("FAIL sel11 got %08h exp 00000104", bus.imem_addr);
    end
    do_fetch(32'h1000_0003);
    accept(PC_IMM, 32'h0);
    step();
    checks++;
    if (bus.imem_addr !== 32'h114) begin
      errors++; $display("FAIL imm_pos got %08h exp 00000114", bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    jump_to(32'hFFFF_FFFC);
    do_fetch(32'h0);
    checks++;
    if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin
      errors++; $display("FAIL wrap_pc got pc=%08h pc4=%08h exp fffffffc/00000000", bus.pc, bus.pc_plus4);
    end
    accept(PC_NEXT, 32'h0);
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next got req=%0b addr=%08h exp 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_timeout();
    int high_cycles = 1;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.imem_req === 1'b1) high_cycles++;
    end
    checks++;
    if (high_cycles != 15) begin
      errors++; $display("FAIL timeout_len got %0d req cycles exp 15", high_cycles);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL timeout_drop got req=%0b exp 0", bus.imem_req);
    end
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++; $display("FAIL timeout_retry got req=%0b addr=%08h exp 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_reset_midfetch();
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.pc !== 32'h40) begin
      errors++; $display("FAIL midreset got req=%0b pc=%08h exp 0/00000040", bus.imem_req, bus.pc);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    step();
    reset = 1'b0;
    step();
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL restart got req=%0b addr=%08h valid=%0b exp 1/00000040/0",
                         bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.opcode !== 4'h0) begin
      errors++; $display("FAIL spurious_ack got valid=%0b opcode=%0h exp 0/0", bus.out_valid, bus.opcode);
    end
  endtask

  task automatic test_misalign();
    do_fetch(32'h0);
    accept(PC_ALU, 32'h202);
`ifdef IF_MISALIGN_TRAP_EN
    begin
      int req_seen = 0;
      checks++;
      if (bus.misalign !== 1'b1 || bus.imem_req !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL trap_enter got mis=%0b req=%0b valid=%0b exp 1/0/0",
                           bus.misalign, bus.imem_req, bus.out_valid);
      end
      for (int i = 0; i < 6; i++) begin
        step();
        if (bus.imem_req !== 1'b0 || bus.misalign !== 1'b1) req_seen++;
      end
      checks++;
      if (req_seen != 0) begin
        errors++; $display("FAIL trap_hold got %0d bad cycles exp 0", req_seen);
      end
    end
`else
    step();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
      errors++; $display("FAIL align_clear got req=%0b addr=%08h exp 1/00000200", bus.imem_req, bus.imem_addr);
    end
`endif
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.out_ready  = 1'b0;
    bus.pc_sel     = PC_NEXT;
    bus.alu_target = 32'h0;
    test_reset();
    test_fetch();
    test_hold();
    test_branch();
    test_wrap();
    test_timeout();
    test_reset_midfetch();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
